bcd_seg_scan: RTL



---
 rtl/bcd_seg_scan_if.sv | 12 +
 rtl/bcd_seg_scan.sv | 114 +++++++++++
 2 files changed

// File: rtl/bcd_seg_scan_if.sv
// Display-side bundle between the BCD source/control and the seven-segment scan driver.
// Carries the BCD value, load strobe, enable, and the active-low select and segment outputs.
interface bcd_seg_scan_if;
    logic [11:0] bcd_in;
    logic        load;
    logic        en;
    logic [2:0]  sel;
    logic [7:0]  seg;

    modport master (output bcd_in, load, en, input sel, seg);
    modport slave  (input bcd_in, load, en, output sel, seg);
endinterface

// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed seven-segment scan driver (common anode, active-low) with leading-zero blanking.
// Latency: disp captures 1 edge after load; a digit shows on the next tick selecting it; en low darkens in 1 edge. No backpressure.
module bcd_seg_scan #(
    parameter int SCAN_CNT_MAX = 50_000
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    bcd_seg_scan_if.slave  bus
);
    localparam int            CW       = $clog2(SCAN_CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT_MAX - 1);

    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2,
        DIG_BAD   = 2'd3
    } digit_e;

    logic [CW-1:0] cnt_q, cnt_d;
    digit_e        idx_q, idx_d;
    logic [11:0]   disp_q, disp_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hBF;
        endcase
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            idx_q  <= DIG_HUNDS;
            disp_q <= '0;
            sel_q  <= 3'b111;
            seg_q  <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = cnt_q + CW'(1);
        idx_d  = idx_q;
        disp_d = disp_q;
        sel_d  = sel_q;
        seg_d  = seg_q;
        nib    = disp_q[3:0];
        blank  = 1'b0;

        if (tick) begin
            cnt_d = '0;
            case (idx_q)
                DIG_UNITS: idx_d = DIG_TENS;
                DIG_TENS:  idx_d = DIG_HUNDS;
                default:   idx_d = DIG_UNITS;
            endcase
        end

        if (bus.load) disp_d = bus.bcd_in;

        // Decode from the pre-edge disp so a coincident load waits for the following tick.
        case (idx_d)
            DIG_TENS: begin
                nib   = disp_q[7:4];
                blank = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
            end
            DIG_HUNDS: begin
                nib   = disp_q[11:8];
                blank = (disp_q[11:8] == 4'd0);
            end
            default: begin
                nib   = disp_q[3:0];
                blank = 1'b0;
            end
        endcase

        if (!bus.en) begin
            sel_d = 3'b111;
            seg_d = 8'hFF;
        end else if (tick) begin
            case (idx_d)
                DIG_UNITS: sel_d = 3'b110;
                DIG_TENS:  sel_d = 3'b101;
                DIG_HUNDS: sel_d = 3'b011;
                default:   sel_d = 3'b111;
            endcase
            seg_d = blank ? 8'hFF : seg_decode(nib);
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;
endmodule
